shift_serializer: RTL and testbench

- Parallel-in/serial-out stage that feeds a serial link.
- Accepts an n-bit word over a valid/ready handshake, loads it into an internal shift register, and emits it one bit per accepted beat on a serial valid/ready interface.
- Sits downstream of the parallel-load producer and upstream of a serial consumer. Frame markers on the first and last bit let the consumer re-assemble words.
- Supports gapless back-to-back words.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/ser_bit_counter.sv | 44 ++++
 rtl/shift_serializer.sv | 137 +++++++++++++
 tb/tb_shift_serializer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the parallel-in/serial-out link stage.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Value shifted into the vacated end of the shift register.
  localparam logic FILL_BIT = 1'b0;

  // Bit counter width; a one-bit word still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned words);
    if (words <= 1) begin
      return 1;
    end
    return $clog2(words);
  endfunction

endpackage : shift_pkg

// File: rtl/ser_bit_counter.sv
// Bit position within the word being serialized, with registered first/last flags.
module ser_bit_counter
  import shift_pkg::*;
#(
  parameter int unsigned n = 3,
  localparam int unsigned CNT_W = cnt_width(n)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  input  logic             load_zero,
  output logic [CNT_W-1:0] count,
  output logic             at_first,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

  logic [CNT_W-1:0] count_nxt;

  // Restart beats a step; a step never moves past the last bit position.
  always_comb begin
    count_nxt = count;
    if (load_zero) begin
      count_nxt = '0;
    end else if (inc && (count != LAST_CNT)) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // Flags are registered alongside the count so they decode no logic downstream.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count    <= '0;
      at_first <= 1'b1;
      at_last  <= (LAST_CNT == '0);
    end else begin
      count    <= count_nxt;
      at_first <= (count_nxt == '0);
      at_last  <= (count_nxt == LAST_CNT);
    end
  end

endmodule : ser_bit_counter

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out stage: loads an n-bit word on a valid/ready handshake and
// emits it one bit per serial transfer, with first/last frame markers.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int unsigned n         = 3,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_first,
  output logic         ser_last,
  output logic         busy
);

  localparam int unsigned      CNT_W    = cnt_width(n);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

  state_t           state;
  state_t           state_nxt;
  logic [n-1:0]     shreg;
  logic [n-1:0]     shreg_shifted;
  logic             head_bit;
  logic [CNT_W-1:0] count;
  logic             at_first;
  logic             at_last;
  logic             in_xfer;
  logic             ser_xfer;
  logic             word_done;

  assign in_xfer   = in_valid & in_ready;
  assign ser_xfer  = ser_valid & ser_ready;
  assign word_done = ser_xfer & ser_last;

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a waiting word on the last beat keeps the stream gapless.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready && at_last && !in_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; in_ready looks through to ser_ready so a new word can land on the last beat.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    ser_out   = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = head_bit;
        ser_first = at_first;
        ser_last  = at_last;
        in_ready  = at_last & ser_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Output end of the register and its one-position advance toward that end.
  always_comb begin
    if (LSB_FIRST) begin
      head_bit      = shreg[0];
      shreg_shifted = n'({FILL_BIT, shreg} >> 1);
    end else begin
      head_bit      = shreg[n-1];
      shreg_shifted = n'({shreg, FILL_BIT});
    end
  end

  // Shift register: a load on the last beat takes priority over the advance.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      shreg <= '0;
    end else if (in_xfer) begin
      shreg <= in_data;
    end else if (ser_xfer) begin
      shreg <= shreg_shifted;
    end
  end

  ser_bit_counter #(
    .n(n)
  ) u_bit_counter (
    .clock    (clock),
    .clear    (clear),
    .inc      (ser_xfer & ~ser_last),
    .load_zero(in_xfer | word_done),
    .count    (count),
    .at_first (at_first),
    .at_last  (at_last)
  );

  // The counter must never run past the last bit of a word.
  count_in_range: assert property (@(posedge clock) disable iff (clear)
    count <= LAST_CNT);

  // A stalled bit and its markers hold until the consumer takes them.
  hold_under_backpressure: assert property (@(posedge clock) disable iff (clear)
    (ser_valid && !ser_ready) |=> (ser_valid && $stable(ser_out)
                                   && $stable(ser_first) && $stable(ser_last)));

endmodule : shift_serializer

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: three instances (n=3 LSB-first, n=3 MSB-first, n=1)
// checked each cycle against a queue-of-bits model, plus directed literal checks.
module tb_shift_serializer;

  logic       clk;
  logic       clear;
  logic [2:0] in_data [3];
  logic [2:0] in_valid;
  logic [2:0] ser_ready;
  logic [2:0] in_ready;
  logic [2:0] ser_out;
  logic [2:0] ser_valid;
  logic [2:0] ser_first;
  logic [2:0] ser_last;
  logic [2:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_serializer #(.n(3), .LSB_FIRST(1'b1)) u_lsb (
    .clock(clk), .clear(clear), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .ser_first(ser_first[0]), .ser_last(ser_last[0]),
    .busy(busy[0]));

  shift_serializer #(.n(3), .LSB_FIRST(1'b0)) u_msb (
    .clock(clk), .clear(clear), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .ser_first(ser_first[1]), .ser_last(ser_last[1]),
    .busy(busy[1]));

  shift_serializer #(.n(1), .LSB_FIRST(1'b1)) u_one (
    .clock(clk), .clear(clear), .in_data(in_data[2][0:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
    .ser_ready(ser_ready[2]), .ser_first(ser_first[2]), .ser_last(ser_last[2]),
    .busy(busy[2]));

  task automatic chk(input string nm, input int d, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: per instance, the bits still owed to the consumer with their markers.
  int   wn   [3] = '{3, 3, 1};
  bit   lsbf [3] = '{1'b1, 1'b0, 1'b1};
  logic pb   [3][8];
  logic pf   [3][8];
  logic pl   [3][8];
  int   pn   [3] = '{0, 0, 0};
  logic m_ev;
  logic m_er;
  int   m_idx;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (clear) begin
        pn[d] = 0;
        chk("rst_in_ready", d, in_ready[d], 1'b1);
        chk("rst_ser_valid", d, ser_valid[d], 1'b0);
        chk("rst_ser_out", d, ser_out[d], 1'b0);
        chk("rst_ser_first", d, ser_first[d], 1'b0);
        chk("rst_ser_last", d, ser_last[d], 1'b0);
        chk("rst_busy", d, busy[d], 1'b0);
      end else begin
        m_ev = (pn[d] > 0);
        m_er = !m_ev || (pn[d] == 1 && ser_ready[d]);
        chk("in_ready", d, in_ready[d], m_er);
        chk("ser_valid", d, ser_valid[d], m_ev);
        chk("busy", d, busy[d], m_ev);
        if (m_ev) begin
          chk("ser_out", d, ser_out[d], pb[d][0]);
          chk("ser_first", d, ser_first[d], pf[d][0]);
          chk("ser_last", d, ser_last[d], pl[d][0]);
          if (ser_ready[d]) begin
            for (int k = 0; k < 7; k++) begin
              pb[d][k] = pb[d][k+1];
              pf[d][k] = pf[d][k+1];
              pl[d][k] = pl[d][k+1];
            end
            pn[d]--;
          end
        end
        if (in_valid[d] && m_er) begin
          for (int k = 0; k < wn[d]; k++) begin
            m_idx = lsbf[d] ? k : wn[d] - 1 - k;
            pb[d][pn[d]] = in_data[d][m_idx];
            pf[d][pn[d]] = (k == 0);
            pl[d][pn[d]] = (k == wn[d] - 1);
            pn[d]++;
          end
        end
      end
    end
  end

  // Record of delivered bits and valid cycles, for the literal sequence checks.
  logic [31:0] cb [3];
  logic [31:0] cf [3];
  logic [31:0] cl [3];
  int          cc [3];
  int          vc [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!clear && ser_valid[d]) begin
        vc[d]++;
        if (ser_ready[d]) begin
          cb[d] = {cb[d][30:0], ser_out[d]};
          cf[d] = {cf[d][30:0], ser_first[d]};
          cl[d] = {cl[d][30:0], ser_last[d]};
          cc[d]++;
        end
      end
    end
  end

  task automatic clr_cap();
    for (int d = 0; d < 3; d++) begin
      cb[d] = '0; cf[d] = '0; cl[d] = '0; cc[d] = 0; vc[d] = 0;
    end
  endtask

  // Wait (bounded) for the negedge where in_ready is seen; returns cycles waited.
  task automatic wait_ready(input int d, output int k);
    bit ok;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 50) begin
      @(negedge clk);
      k++;
      if (in_ready[d]) ok = 1'b1;
    end
    chk("accept_in_time", d, ok, 1'b1);
  endtask

  task automatic send(input int d, input logic [2:0] w);
    int k;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    wait_ready(d, k);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  bit   acc [3];
  int   k;
  logic [2:0] seq [3];

  initial begin
    clear     = 1'b1;
    in_valid  = '0;
    ser_ready = '0;
    for (int d = 0; d < 3; d++) in_data[d] = '0;
    clr_cap();
    #3;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ser_valid", d, ser_valid[d], 1'b0);
      chk("reset_in_ready", d, in_ready[d], 1'b1);
    end
    repeat (3) @(posedge clk);
    #2 clear = 1'b0;
    idle_cycles(1);

    // Single word LSB-first: 3'b110 -> 0,1,1
    ser_ready[0] = 1'b1;
    clr_cap();
    send(0, 3'b110);
    chk("first_bit_valid", 0, ser_valid[0], 1'b1);
    chk("first_bit_value", 0, ser_out[0], 1'b0);
    chk("first_bit_marker", 0, ser_first[0], 1'b1);
    idle_cycles(5);
    chk_v("lsb_bits", 0, int'(cb[0][2:0]), 3'b011);
    chk_v("lsb_first_marks", 0, int'(cf[0][2:0]), 3'b100);
    chk_v("lsb_last_marks", 0, int'(cl[0][2:0]), 3'b001);
    chk_v("lsb_count", 0, cc[0], 3);
    chk("lsb_idle_valid", 0, ser_valid[0], 1'b0);
    chk("lsb_idle_ready", 0, in_ready[0], 1'b1);

    // Single word MSB-first: 3'b100 -> 1,0,0
    ser_ready[1] = 1'b1;
    clr_cap();
    send(1, 3'b100);
    idle_cycles(5);
    chk_v("msb_bits", 1, int'(cb[1][2:0]), 3'b100);
    chk_v("msb_count", 1, cc[1], 3);

    // Backpressure on the second bit of 3'b101
    clr_cap();
    send(0, 3'b101);
    @(posedge clk); #1;
    ser_ready[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", 0, ser_valid[0], 1'b1);
      chk("bp_out", 0, ser_out[0], 1'b0);
      chk("bp_first", 0, ser_first[0], 1'b0);
      chk("bp_last", 0, ser_last[0], 1'b0);
      chk("bp_in_ready", 0, in_ready[0], 1'b0);
    end
    @(posedge clk); #1;
    ser_ready[0] = 1'b1;
    idle_cycles(4);
    chk_v("bp_bits", 0, int'(cb[0][2:0]), 3'b101);
    chk_v("bp_count", 0, cc[0], 3);

    // Back-to-back 3'b011 then 3'b100 -> 1,1,0,0,0,1 gapless
    clr_cap();
    in_data[0]  = 3'b011;
    in_valid[0] = 1'b1;
    wait_ready(0, k);
    @(posedge clk); #1;
    in_data[0] = 3'b100;
    wait_ready(0, k);
    chk_v("b2b_ready_cycle", 0, k, 3);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    idle_cycles(6);
    chk_v("b2b_bits", 0, int'(cb[0][5:0]), 6'b110001);
    chk_v("b2b_valid_cycles", 0, vc[0], 6);
    chk_v("b2b_count", 0, cc[0], 6);

    // Asynchronous reset after the first bit of 3'b111
    clr_cap();
    send(0, 3'b111);
    @(posedge clk); #2;
    clear = 1'b1;
    #1;
    chk("async_valid", 0, ser_valid[0], 1'b0);
    chk("async_busy", 0, busy[0], 1'b0);
    chk("async_last", 0, ser_last[0], 1'b0);
    @(posedge clk); #2;
    clear = 1'b0;
    idle_cycles(4);
    chk_v("async_bits_seen", 0, cc[0], 1);
    chk("async_idle_ready", 0, in_ready[0], 1'b1);
    chk("async_idle_valid", 0, ser_valid[0], 1'b0);

    // n=1 stream 1,0,1
    ser_ready[2] = 1'b1;
    clr_cap();
    seq[0] = 3'b001; seq[1] = 3'b000; seq[2] = 3'b001;
    in_valid[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[2] = seq[i];
      wait_ready(2, k);
      @(posedge clk); #1;
    end
    in_valid[2] = 1'b0;
    idle_cycles(4);
    chk_v("n1_bits", 2, int'(cb[2][2:0]), 3'b101);
    chk_v("n1_first_marks", 2, int'(cf[2][2:0]), 3'b111);
    chk_v("n1_last_marks", 2, int'(cl[2][2:0]), 3'b111);
    chk_v("n1_valid_cycles", 2, vc[2], 3);

    // Random traffic on all instances, producer holds a word until accepted
    for (int d = 0; d < 3; d++) acc[d] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) acc[d] = in_valid[d] & in_ready[d];
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (!in_valid[d] || acc[d]) begin
          in_valid[d] = ($urandom_range(0, 3) != 0);
          in_data[d]  = 3'($urandom);
        end
        ser_ready[d] = ($urandom_range(0, 9) < 7);
      end
      #1;
      if (clear) clear = 1'b0;
      else if ($urandom_range(0, 299) == 0) clear = 1'b1;
    end
    #1 clear = 1'b0;
    in_valid = '0;
    idle_cycles(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_serializer
